// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: execution controller wrapped around the combinational 8-bit ALU.
//
// Accepts one operation at a time over in_valid/in_ready and latches the operands.
// The latched operands drive the ALU for one EXEC cycle. The ALU result and flags are
// captured into acc/flags, then held in DONE until out_ready. In DONE, a new operation
// can be accepted in the same cycle that the previous result is consumed.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    upstream handshake; in_op, in_a, in_b, in_use_acc, in_use_carry
//   alu_a/b/opcode/cin   ALU operand drive (always from the operand registers)
//   alu_result/zero/carry/overflow/negative  ALU outputs
//   acc, flags {Z,C,V,N}, out_err            result registers
//   out_valid/out_ready  downstream handshake
//   busy                 controller not idle
//
// Optional feature: define ALU_EXEC_CTRL_CARRY_CHAIN_EN so that in_use_carry selects the
// stored C flag as the ALU carry-in (ADC/SBC-style multi-byte chains). When the macro is
// undefined, the carry-in is always 0.

module alu_exec_ctrl #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_use_acc,
    input  logic              in_use_carry,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_opcode,
    output logic              alu_cin,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_carry,
    input  logic              alu_overflow,
    input  logic              alu_negative,
    output logic [DATA_W-1:0] acc,
    output logic [3:0]        flags,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_err,
    output logic              busy
);

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [DATA_W-1:0] op_a_q, op_b_q;
    logic [3:0]        op_code_q;
    logic              op_cin_q;
    logic [DATA_W-1:0] acc_q;
    logic [3:0]        flags_q;
    logic              err_q;

    logic accept;
    logic cin_sel;
    logic op_legal;

`ifdef ALU_EXEC_CTRL_CARRY_CHAIN_EN
    // flags_q already holds the just-completed carry when accepting from DONE.
    assign cin_sel = in_use_carry & flags_q[2];
`else
    logic unused_in_use_carry;
    assign unused_in_use_carry = in_use_carry;
    assign cin_sel = 1'b0;
`endif

    assign op_legal = (op_code_q <= 4'd9);
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) state_d = StExec;
            end
            StExec: state_d = StDone;
            StDone: begin
                // Direct accept: consuming the result frees the slot this same cycle.
                in_ready = out_ready;
                if (out_ready) state_d = in_valid ? StExec : StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (rst) in_ready = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            op_a_q    <= '0;
            op_b_q    <= '0;
            op_code_q <= '0;
            op_cin_q  <= 1'b0;
            acc_q     <= '0;
            flags_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_a_q    <= in_use_acc ? acc_q : in_a;
                op_b_q    <= in_b;
                op_code_q <= in_op;
                op_cin_q  <= cin_sel;
            end
            if (state_q == StExec) begin
                if (op_legal) begin
                    acc_q   <= alu_result;
                    flags_q <= {alu_zero, alu_carry, alu_overflow, alu_negative};
                    err_q   <= 1'b0;
                end else begin
                    err_q   <= 1'b1;
                end
            end
        end
    end

    assign alu_a      = op_a_q;
    assign alu_b      = op_b_q;
    assign alu_opcode = op_code_q;
    assign alu_cin    = op_cin_q;
    assign acc        = acc_q;
    assign flags      = flags_q;
    assign out_err    = err_q;
    assign out_valid  = (state_q == StDone);
    assign busy       = (state_q != StIdle);

endmodule
